upcounter_ctrl: RTL and testbench
=================================

// Module: upcounter_ctrl
// PURPOSE
//  Run/stop/clear controller and tick scheduler for the up-counter display path.
//  Replaces a derived slow clock with a single-cycle enable (o_tick) in the i_clk domain.
//  Takes raw run/clear button levels, sequences the counter through STOP/RUN/CLEAR,
//  and owns the BCD-range count value fed to the FND decoder.
// PARAMETERS
//  CLK_HZ     100_000_000  input clock frequency (Hz)
//  TICK_HZ    10           count rate while running (Hz); DIV = CLK_HZ/TICK_HZ, DIV >= 2
//  MAX_COUNT  9999         terminal count; wraps to 0 after this value
//  CNT_W      14           width of o_count; must hold MAX_COUNT
// PORTS
//  i_clk        in   1      system clock
//  i_reset_n    in   1      asynchronous, active-low reset
//  i_btn_run    in   1      run/stop button level, asynchronous, debounced upstream
//  i_btn_clear  in   1      clear button level, asynchronous, debounced upstream
//  o_count      out  CNT_W  current count, 0..MAX_COUNT
//  o_tick       out  1      one-cycle pulse on each prescaler terminal while RUN
//  o_wrap       out  1      one-cycle pulse when count wraps MAX_COUNT->0
//  o_running    out  1      high while state == RUN
//  o_state      out  2      STOP=2'b00, RUN=2'b01, CLEAR=2'b10
// BEHAVIOUR
//  - Reset (i_reset_n=0, async): state=STOP, prescaler=0, o_count=0, o_tick=0, o_wrap=0,
//    o_running=0, synchronizer/edge registers=0. All outputs registered.
//  - Each button: 2-FF synchronizer, then rising-edge detect (sync2 & ~prev). A level rising
//    before clock edge k produces state change at edge k+2 (edge-detect output valid
//    after edge k+1, FSM registers it at edge k+2). Held levels give one event only.
//  - FSM:
//    STOP : run_evt -> RUN; clear_evt -> CLEAR.
//    RUN  : run_evt -> STOP; clear_evt -> CLEAR.
//    CLEAR: one cycle; o_count<=0, prescaler<=0; unconditionally -> STOP.
//  - Priority: clear_evt beats run_evt in the same cycle (-> CLEAR). Events arriving while
//    in CLEAR are dropped.
//  - Prescaler (width clog2(DIV)): counts 0..DIV-1 only in RUN; cleared to 0 on any exit
//    from RUN and in CLEAR, so every RUN entry yields first tick exactly DIV cycles later.
//  - o_tick=1 for the cycle after the prescaler sat at DIV-1 in RUN; in the same edge
//    o_count increments (o_tick and new count appear together).
//  - Stop wins: if run_evt and prescaler==DIV-1 coincide in RUN, no tick, no increment.
//  - Wrap: count==MAX_COUNT at a tick -> 0 and o_wrap=1 for that cycle (with o_tick).
//  - STOP holds o_count; resuming continues from held value.
//  - Reset asserted mid-operation: immediate return to reset values, no pending events kept.
// CONFIGURATION
//  UPCNT_DOWN_EN defined: adds port i_dir (in, 1, sampled via 2-FF sync, level-used).
//    i_dir=1 counts down on each tick; 0 -> MAX_COUNT with o_wrap pulse. i_dir=0 counts up.
//    Direction change takes effect at the next tick; prescaler unaffected.
//  UPCNT_DOWN_EN undefined: no i_dir port; up-count only as above.
// TESTING (bench params CLK_HZ=100, TICK_HZ=10 -> DIV=10, MAX_COUNT=9, CNT_W=4)
//  - Reset: hold i_reset_n=0 mid-RUN with count=5 -> o_count=0, o_state=00, all pulses 0
//    within same cycle, no tick afterwards without new run press.
//  - Run: rise i_btn_run before edge 0 -> o_state=01 at edge 2; first o_tick + o_count=1
//    at edge 12; o_count=3 at edge 32; one event despite button held 50 cycles.
//  - Wrap: run through 10 ticks -> o_count 9->0 with o_tick=1 and o_wrap=1 same cycle.
//  - Stop/resume: stop at count=4 -> count holds 4 for 100 cycles; restart -> count=5
//    exactly 10 cycles after RUN entry.
//  - Simultaneous: both buttons rise same cycle in RUN at count=7 -> CLEAR one cycle,
//    then STOP, o_count=0; also run_evt at prescaler==9 -> STOP, no increment.
//  - UPCNT_DOWN_EN build: i_dir=1 from count=1 -> 0 then 9 with o_wrap=1; i_dir=0 restores up.

Source files
------------

// File: rtl/upcounter_ctrl.sv
// rtl/upcounter_ctrl.sv - run/stop/clear controller and tick scheduler for the up-counter display path
// Optional feature macro: UPCNT_DOWN_EN (adds i_dir, down-count with wrap to MAX_COUNT)
module upcounter_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TICK_HZ   = 10,
  parameter int MAX_COUNT = 9999,
  parameter int CNT_W     = 14
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_btn_run,
  input  logic             i_btn_clear,
`ifdef UPCNT_DOWN_EN
  input  logic             i_dir,
`endif
  output logic [CNT_W-1:0] o_count,
  output logic             o_tick,
  output logic             o_wrap,
  output logic             o_running,
  output logic [1:0]       o_state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [1:0]       run_sync;
  logic [1:0]       clear_sync;
  logic             run_prev;
  logic             clear_prev;
  logic             run_evt;
  logic             clear_evt;
  logic             count_down;
  logic [PW-1:0]    presc_q;
  logic [PW-1:0]    presc_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tick_d;
  logic             wrap_d;

  // Button levels are asynchronous: two flops before the edge detector.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run_sync   <= 2'b00;
      clear_sync <= 2'b00;
      run_prev   <= 1'b0;
      clear_prev <= 1'b0;
    end else begin
      run_sync   <= {run_sync[0], i_btn_run};
      clear_sync <= {clear_sync[0], i_btn_clear};
      run_prev   <= run_sync[1];
      clear_prev <= clear_sync[1];
    end
  end

  assign run_evt   = run_sync[1] & ~run_prev;
  assign clear_evt = clear_sync[1] & ~clear_prev;

`ifdef UPCNT_DOWN_EN
  logic [1:0] dir_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dir_sync <= 2'b00;
    end else begin
      dir_sync <= {dir_sync[0], i_dir};
    end
  end

  assign count_down = dir_sync[1];
`else
  assign count_down = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_STOP;
    end else begin
      state <= next_state;
    end
  end

  // Clear outranks run; anything arriving during CLEAR is dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_STOP: begin
        if (clear_evt)    next_state = ST_CLEAR;
        else if (run_evt) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (clear_evt)    next_state = ST_CLEAR;
        else if (run_evt) next_state = ST_STOP;
      end
      default: next_state = ST_STOP;
    endcase
  end

  always_comb begin
    presc_d = '0;
    count_d = count_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state)
      ST_RUN: begin
        // A stop press landing on the terminal cycle cancels that tick.
        if (presc_q == PRESC_LAST) begin
          tick_d = ~run_evt;
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (next_state != ST_RUN) begin
          presc_d = '0;
        end
        if (tick_d) begin
          if (count_down) begin
            if (count_q == '0) begin
              count_d = CNT_MAX;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end else begin
            if (count_q == CNT_MAX) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
      end
      ST_CLEAR: count_d = '0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q   <= '0;
      count_q   <= '0;
      o_tick    <= 1'b0;
      o_wrap    <= 1'b0;
      o_running <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      o_tick    <= tick_d;
      o_wrap    <= wrap_d;
      o_running <= (next_state == ST_RUN);
    end
  end

  assign o_count = count_q;
  assign o_state = state;

endmodule

// File: tb/tb_upcounter_ctrl.sv
// tb/tb_upcounter_ctrl.sv - self-checking bench for upcounter_ctrl with a cycle-level reference model
module tb_upcounter_ctrl;

  localparam int CLK_HZ    = 100;
  localparam int TICK_HZ   = 10;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int MAX_COUNT = 9;
  localparam int CNT_W     = 4;

  logic             i_clk = 1'b0;
  logic             i_reset_n = 1'b0;
  logic             i_btn_run = 1'b0;
  logic             i_btn_clear = 1'b0;
`ifdef UPCNT_DOWN_EN
  logic             i_dir = 1'b0;
`endif
  logic [CNT_W-1:0] o_count;
  logic             o_tick;
  logic             o_wrap;
  logic             o_running;
  logic [1:0]       o_state;

  upcounter_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_COUNT(MAX_COUNT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_btn_run(i_btn_run),
    .i_btn_clear(i_btn_clear),
`ifdef UPCNT_DOWN_EN
    .i_dir(i_dir),
`endif
    .o_count(o_count),
    .o_tick(o_tick),
    .o_wrap(o_wrap),
    .o_running(o_running),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: button levels seen at edge n act at edge n+2; ticks fall every DIV edges after RUN entry.
  int       m_state = 0;
  int       m_count = 0;
  int       m_tick  = 0;
  int       m_wrap  = 0;
  int       m_entry = 0;
  int       cyc     = 0;
  bit [3:1] h_run   = '0;
  bit [3:1] h_clr   = '0;
  bit [3:1] h_dir   = '0;
  bit       ev_run;
  bit       ev_clr;
  bit       m_down;

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_state = 0; m_count = 0; m_tick = 0; m_wrap = 0;
      h_run = '0; h_clr = '0; h_dir = '0;
    end else begin
      cyc++;
      ev_run = h_run[2] & ~h_run[3];
      ev_clr = h_clr[2] & ~h_clr[3];
      m_down = h_dir[2];
      m_tick = 0;
      m_wrap = 0;
      case (m_state)
        0: begin
          if (ev_clr) m_state = 2;
          else if (ev_run) begin m_state = 1; m_entry = cyc; end
        end
        1: begin
          if (((cyc - m_entry) % DIV == 0) && !ev_run) begin
            m_tick = 1;
            if (m_down) begin
              if (m_count == 0) begin m_count = MAX_COUNT; m_wrap = 1; end
              else m_count = m_count - 1;
            end else begin
              if (m_count == MAX_COUNT) begin m_count = 0; m_wrap = 1; end
              else m_count = m_count + 1;
            end
          end
          if (ev_clr) m_state = 2;
          else if (ev_run) m_state = 0;
        end
        default: begin m_count = 0; m_state = 0; end
      endcase
      h_run = {h_run[2:1], i_btn_run};
      h_clr = {h_clr[2:1], i_btn_clear};
`ifdef UPCNT_DOWN_EN
      h_dir = {h_dir[2:1], i_dir};
`endif
    end
  end

  bit chk_en = 1'b0;

  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model_state", o_state, m_state);
      check("model_count", o_count, m_count);
      check("model_tick", o_tick, m_tick);
      check("model_wrap", o_wrap, m_wrap);
      check("model_running", o_running, (m_state == 1) ? 1 : 0);
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic press_run();
    i_btn_run = 1'b1;
    @(negedge i_clk);
    i_btn_run = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    chk_en    = 1'b1;
    check("rst_state", o_state, 0);
    check("rst_count", o_count, 0);
    check("rst_tick", o_tick, 0);
    check("rst_running", o_running, 0);

    // Run held for 50 cycles: one event, ticks at edges 12, 22, 32, ...
    i_btn_run = 1'b1;
    wait_edges(3);
    check("run_entry_state", o_state, 1);
    wait_edges(9);
    check("pre_tick", o_tick, 0);
    check("pre_tick_count", o_count, 0);
    wait_edges(1);
    check("first_tick", o_tick, 1);
    check("first_count", o_count, 1);
    wait_edges(20);
    check("count_e32", o_count, 3);
    wait_edges(18);
    i_btn_run = 1'b0;
    wait_edges(2);
    check("held_count", o_count, 5);
    check("held_state", o_state, 1);

    // Asynchronous reset mid-RUN
    #2 i_reset_n = 1'b0;
    #1;
    check("async_rst_count", o_count, 0);
    check("async_rst_state", o_state, 0);
    check("async_rst_tick", o_tick, 0);
    check("async_rst_wrap", o_wrap, 0);
    check("async_rst_running", o_running, 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    wait_edges(30);
    check("post_rst_count", o_count, 0);
    check("post_rst_state", o_state, 0);

    // Wrap on the tenth tick
    press_run();
    wait_edges(101);
    check("pre_wrap_count", o_count, 9);
    wait_edges(1);
    check("wrap_count", o_count, 0);
    check("wrap_tick", o_tick, 1);
    check("wrap_flag", o_wrap, 1);

    // Stop at 4, hold, resume
    wait_edges(40);
    check("stop_at_count", o_count, 4);
    press_run();
    wait_edges(2);
    check("stopped_state", o_state, 0);
    wait_edges(100);
    check("stop_hold_count", o_count, 4);
    press_run();
    wait_edges(11);
    check("resume_pre_count", o_count, 4);
    check("resume_state", o_state, 1);
    wait_edges(1);
    check("resume_count", o_count, 5);
    check("resume_tick", o_tick, 1);

    // Both buttons in the same cycle at count 7
    wait_edges(20);
    check("both_pre_count", o_count, 7);
    i_btn_run = 1'b1; i_btn_clear = 1'b1;
    @(negedge i_clk);
    i_btn_run = 1'b0; i_btn_clear = 1'b0;
    wait_edges(2);
    check("both_clear_state", o_state, 2);
    wait_edges(1);
    check("both_stop_state", o_state, 0);
    check("both_count", o_count, 0);

    // Stop press landing on the terminal prescaler cycle
    press_run();
    wait_edges(19);
    check("term_pre_count", o_count, 1);
    press_run();
    wait_edges(2);
    check("term_state", o_state, 0);
    check("term_count", o_count, 1);
    check("term_tick", o_tick, 0);
    wait_edges(20);
    check("term_hold_count", o_count, 1);

`ifdef UPCNT_DOWN_EN
    press_run();
    wait_edges(12);
    check("dn_up_count", o_count, 2);
    i_dir = 1'b1;
    wait_edges(10);
    check("dn_count1", o_count, 1);
    wait_edges(10);
    check("dn_count0", o_count, 0);
    wait_edges(10);
    check("dn_wrap_count", o_count, 9);
    check("dn_wrap_flag", o_wrap, 1);
    i_dir = 1'b0;
    wait_edges(10);
    check("up_again_count", o_count, 0);
    check("up_again_wrap", o_wrap, 1);
    press_run();
    wait_edges(3);
`endif

    // Randomized levels, occasional one-cycle resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge i_clk);
      #1;
      if ($urandom_range(0, 99) < 3) i_btn_run = ~i_btn_run;
      if ($urandom_range(0, 99) < 1) i_btn_clear = ~i_btn_clear;
`ifdef UPCNT_DOWN_EN
      if ($urandom_range(0, 99) < 2) i_dir = ~i_dir;
`endif
      i_reset_n = ($urandom_range(0, 799) != 0);
    end
    @(negedge i_clk);
    #1 i_reset_n = 1'b1;
    wait_edges(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
